decode_stage_v2: RTL and testbench

Next-generation instruction-decode stage for the 5-stage MIPS core. It sits between the IF/ID register and EX, and integrates:
- Field decode and sign/zero extension.
- A parametrised register file.
- Load-use hazard detection with bubble insertion.
- A registered ID/EX output stage with valid/ready handshake and flush.

The previous decode top had no pipeline register, no hazard logic and a fixed register count.

---
 rtl/decode_stage_v2.sv | 250 +++++++++++++++++++++++++
 tb/tb_decode_stage_v2.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_v2.sv
// MIPS decode stage: field decode, register file, load-use stall and a registered ID/EX stage.
// Optional build macro DECODE_WB_BYPASS_EN forwards a same-cycle WB write into the captured operands.
module decode_stage_v2 #(
  parameter int               NBITS    = 32,
  parameter int               NREGS    = 32,
  parameter logic [NBITS-1:0] PC_RESET = {NBITS{1'b0}}
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NBITS-1:0]         i_pc,
  input  logic [NBITS-1:0]         i_instruction,
  input  logic                     i_flush,
  input  logic                     i_wb_en,
  input  logic [$clog2(NREGS)-1:0] i_wb_sel,
  input  logic [NBITS-1:0]         i_wb_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NBITS-1:0]         o_pc,
  output logic [NBITS-1:0]         o_rs_data,
  output logic [NBITS-1:0]         o_rt_data,
  output logic [NBITS-1:0]         o_imm_ext,
  output logic [$clog2(NREGS)-1:0] o_rs,
  output logic [$clog2(NREGS)-1:0] o_rt,
  output logic [$clog2(NREGS)-1:0] o_wr_reg,
  output logic [3:0]               o_alu_op,
  output logic                     o_alu_src_imm,
  output logic                     o_reg_wr,
  output logic                     o_mem_rd,
  output logic                     o_mem_wr,
  output logic                     o_branch_eq,
  output logic                     o_branch_ne,
  output logic                     o_jump,
  output logic                     o_jump_reg,
  output logic                     o_link,
  output logic                     o_illegal
);
  localparam int RA = $clog2(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09, F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND  = 4'd2,  ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA  = 4'd10, ALU_LUI = 4'd11;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic             valid;
    logic [NBITS-1:0] pc;
    logic [NBITS-1:0] rs_data;
    logic [NBITS-1:0] rt_data;
    logic [NBITS-1:0] imm_ext;
    logic [RA-1:0]    rs;
    logic [RA-1:0]    rt;
    logic [RA-1:0]    wr_reg;
    logic [3:0]       alu_op;
    logic             alu_src_imm;
    logic             reg_wr;
    logic             mem_rd;
    logic             mem_wr;
    logic             branch_eq;
    logic             branch_ne;
    logic             jump;
    logic             jump_reg;
    logic             link;
    logic             illegal;
  } idex_t;

  function automatic idex_t idex_clear();
    idex_t c;
    c    = '0;
    c.pc = PC_RESET;
    return c;
  endfunction

  logic [NBITS-1:0] regs_r [NREGS];
  idex_t            idex_r;
  idex_t            dec_s;
  logic [5:0]       opcode_s, funct_s;
  logic [15:0]      imm16_s;
  logic [RA-1:0]    rs_idx_s, rt_idx_s, rd_idx_s;
  logic [NBITS-1:0] rs_data_s, rt_data_s;
  logic [NBITS-1:0] imm_sext_s, imm_zext_s, imm_lui_s, imm_jtgt_s, imm_shamt_s;
  logic             wb_write_s, reads_rt_s, hazard_s, load_s;

  assign opcode_s    = i_instruction[31:26];
  assign funct_s     = i_instruction[5:0];
  assign imm16_s     = i_instruction[15:0];
  assign rs_idx_s    = i_instruction[21 +: RA];
  assign rt_idx_s    = i_instruction[16 +: RA];
  assign rd_idx_s    = i_instruction[11 +: RA];
  assign imm_sext_s  = {{(NBITS-16){imm16_s[15]}}, imm16_s};
  assign imm_zext_s  = {{(NBITS-16){1'b0}}, imm16_s};
  assign imm_lui_s   = imm_zext_s << 5'd16;
  assign imm_jtgt_s  = {{(NBITS-26){1'b0}}, i_instruction[25:0]};
  assign imm_shamt_s = {{(NBITS-5){1'b0}}, i_instruction[10:6]};
  assign wb_write_s  = i_wb_en & (i_wb_sel != {RA{1'b0}});

  // Register file storage; r0 is never written.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= {NBITS{1'b0}};
    end else if (wb_write_s) begin
      regs_r[i_wb_sel] <= i_wb_data;
    end
  end

  // Operand read ports, r0 hard-wired to zero.
  always_comb begin
    if (rs_idx_s == {RA{1'b0}}) rs_data_s = {NBITS{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
    else if (wb_write_s && (i_wb_sel == rs_idx_s)) rs_data_s = i_wb_data;
`endif
    else rs_data_s = regs_r[rs_idx_s];

    if (rt_idx_s == {RA{1'b0}}) rt_data_s = {NBITS{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
    else if (wb_write_s && (i_wb_sel == rt_idx_s)) rt_data_s = i_wb_data;
`endif
    else rt_data_s = regs_r[rt_idx_s];
  end

  // Instruction decode into the next ID/EX contents.
  always_comb begin
    dec_s         = idex_clear();
    dec_s.valid   = 1'b1;
    dec_s.pc      = i_pc;
    dec_s.rs_data = rs_data_s;
    dec_s.rt_data = rt_data_s;
    dec_s.rs      = rs_idx_s;
    dec_s.rt      = rt_idx_s;
    reads_rt_s    = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        reads_rt_s   = 1'b1;
        dec_s.wr_reg = rd_idx_s;
        dec_s.reg_wr = 1'b1;
        case (funct_s)
          F_ADDU: dec_s.alu_op = ALU_ADD;
          F_SUBU: dec_s.alu_op = ALU_SUB;
          F_AND:  dec_s.alu_op = ALU_AND;
          F_OR:   dec_s.alu_op = ALU_OR;
          F_XOR:  dec_s.alu_op = ALU_XOR;
          F_NOR:  dec_s.alu_op = ALU_NOR;
          F_SLT:  dec_s.alu_op = ALU_SLT;
          F_SLTU: dec_s.alu_op = ALU_SLTU;
          F_SLL:  begin dec_s.alu_op = ALU_SLL; dec_s.imm_ext = imm_shamt_s; end
          F_SRL:  begin dec_s.alu_op = ALU_SRL; dec_s.imm_ext = imm_shamt_s; end
          F_SRA:  begin dec_s.alu_op = ALU_SRA; dec_s.imm_ext = imm_shamt_s; end
          F_JR:   begin dec_s.jump_reg = 1'b1; dec_s.reg_wr = 1'b0; end
          F_JALR: begin dec_s.jump_reg = 1'b1; dec_s.link = 1'b1; end
          default: begin dec_s.illegal = 1'b1; dec_s.reg_wr = 1'b0; end
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        dec_s.wr_reg      = rt_idx_s;
        dec_s.reg_wr      = 1'b1;
        dec_s.alu_src_imm = 1'b1;
        dec_s.imm_ext     = imm_sext_s;
        case (opcode_s)
          OP_SLTI:  dec_s.alu_op = ALU_SLT;
          OP_SLTIU: dec_s.alu_op = ALU_SLTU;
          OP_ANDI:  begin dec_s.alu_op = ALU_AND; dec_s.imm_ext = imm_zext_s; end
          OP_ORI:   begin dec_s.alu_op = ALU_OR;  dec_s.imm_ext = imm_zext_s; end
          OP_XORI:  begin dec_s.alu_op = ALU_XOR; dec_s.imm_ext = imm_zext_s; end
          OP_LUI:   begin dec_s.alu_op = ALU_LUI; dec_s.imm_ext = imm_lui_s;  end
          OP_LW:    begin dec_s.alu_op = ALU_ADD; dec_s.mem_rd = 1'b1; end
          default:  dec_s.alu_op = ALU_ADD;
        endcase
      end
      OP_SW: begin
        reads_rt_s        = 1'b1;
        dec_s.wr_reg      = rt_idx_s;
        dec_s.alu_src_imm = 1'b1;
        dec_s.mem_wr      = 1'b1;
        dec_s.imm_ext     = imm_sext_s;
      end
      OP_BEQ, OP_BNE: begin
        reads_rt_s      = 1'b1;
        dec_s.wr_reg    = rt_idx_s;
        dec_s.alu_op    = ALU_SUB;
        dec_s.imm_ext   = imm_sext_s;
        dec_s.branch_eq = (opcode_s == OP_BEQ);
        dec_s.branch_ne = (opcode_s == OP_BNE);
      end
      OP_J: begin
        dec_s.jump    = 1'b1;
        dec_s.imm_ext = imm_jtgt_s;
      end
      OP_JAL: begin
        dec_s.jump    = 1'b1;
        dec_s.link    = 1'b1;
        dec_s.reg_wr  = 1'b1;
        dec_s.wr_reg  = LINK_REG[RA-1:0];
        dec_s.imm_ext = imm_jtgt_s;
      end
      default: dec_s.illegal = 1'b1;
    endcase
  end

  // A load in ID/EX whose target feeds the instruction in decode forces one bubble.
  assign hazard_s = idex_r.valid & idex_r.mem_rd & (idex_r.wr_reg != {RA{1'b0}}) &
                    ((idex_r.wr_reg == rs_idx_s) | ((idex_r.wr_reg == rt_idx_s) & reads_rt_s));
  assign load_s   = ~idex_r.valid | i_ready;
  assign o_ready  = i_flush | (load_s & ~hazard_s);

  // ID/EX pipeline register: flush, load (instruction or bubble) or hold.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      idex_r <= idex_clear();
    end else if (i_flush) begin
      idex_r <= idex_clear();
    end else if (load_s) begin
      if (i_valid && !hazard_s) idex_r <= dec_s;
      else                      idex_r <= idex_clear();
    end
  end

  assign o_valid       = idex_r.valid;
  assign o_pc          = idex_r.pc;
  assign o_rs_data     = idex_r.rs_data;
  assign o_rt_data     = idex_r.rt_data;
  assign o_imm_ext     = idex_r.imm_ext;
  assign o_rs          = idex_r.rs;
  assign o_rt          = idex_r.rt;
  assign o_wr_reg      = idex_r.wr_reg;
  assign o_alu_op      = idex_r.alu_op;
  assign o_alu_src_imm = idex_r.alu_src_imm;
  assign o_reg_wr      = idex_r.reg_wr;
  assign o_mem_rd      = idex_r.mem_rd;
  assign o_mem_wr      = idex_r.mem_wr;
  assign o_branch_eq   = idex_r.branch_eq;
  assign o_branch_ne   = idex_r.branch_ne;
  assign o_jump        = idex_r.jump;
  assign o_jump_reg    = idex_r.jump_reg;
  assign o_link        = idex_r.link;
  assign o_illegal     = idex_r.illegal;

endmodule

// File: tb/tb_decode_stage_v2.sv
// Directed bench for decode_stage_v2 with hand-computed expectations.
module tb_decode_stage_v2;
  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_flush, i_wb_en, i_ready;
  logic [31:0] i_pc, i_instruction, i_wb_data;
  logic [4:0]  i_wb_sel;
  logic        o_ready, o_valid;
  logic [31:0] o_pc, o_rs_data, o_rt_data, o_imm_ext;
  logic [4:0]  o_rs, o_rt, o_wr_reg;
  logic [3:0]  o_alu_op;
  logic        o_alu_src_imm, o_reg_wr, o_mem_rd, o_mem_wr, o_branch_eq, o_branch_ne;
  logic        o_jump, o_jump_reg, o_link, o_illegal;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_bypass;

  decode_stage_v2 dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
    .i_instruction(i_instruction), .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_sel(i_wb_sel),
    .i_wb_data(i_wb_data), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_rs(o_rs),
    .o_rt(o_rt), .o_wr_reg(o_wr_reg), .o_alu_op(o_alu_op), .o_alu_src_imm(o_alu_src_imm),
    .o_reg_wr(o_reg_wr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_branch_eq(o_branch_eq),
    .o_branch_ne(o_branch_ne), .o_jump(o_jump), .o_jump_reg(o_jump_reg), .o_link(o_link),
    .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
    i_valid = 1'b1; i_pc = pc; i_instruction = instr;
    #1;
  endtask

  task automatic wb(input logic [4:0] sel, input logic [31:0] data);
    i_valid = 1'b0; i_wb_en = 1'b1; i_wb_sel = sel; i_wb_data = data;
    step();
    i_wb_en = 1'b0;
  endtask

  initial begin
    i_rst = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_wb_en = 1'b0; i_ready = 1'b1;
    i_pc = 32'h0; i_instruction = 32'h0; i_wb_data = 32'h0; i_wb_sel = 5'd0;
    step(); step();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_rs_data", o_rs_data, 32'h0);
    check("rst_ready", 32'(o_ready), 32'd1);
    i_rst = 1'b1;

    // Basic R-type with operands from the register file
    wb(5'd3, 32'h12345678);
    wb(5'd5, 32'h55555555);
    drive(32'h100, 32'h00632021);          // ADDU r4,r3,r3
    check("addu_ready", 32'(o_ready), 32'd1);
    step();
    check("addu_valid", 32'(o_valid), 32'd1);
    check("addu_rs", o_rs_data, 32'h12345678);
    check("addu_rt", o_rt_data, 32'h12345678);
    check("addu_op", 32'(o_alu_op), 32'd0);
    check("addu_wr", 32'(o_wr_reg), 32'd4);
    check("addu_regwr", 32'(o_reg_wr), 32'd1);
    check("addu_pc", o_pc, 32'h100);

    // Load-use on rs: one bubble
    drive(32'h104, 32'h8C220004);          // LW r2,4(r1)
    step();
    check("lw_memrd", 32'(o_mem_rd), 32'd1);
    check("lw_imm", o_imm_ext, 32'h4);
    drive(32'h108, 32'h00402821);          // ADDU r5,r2,r0
    check("lu_rs_ready", 32'(o_ready), 32'd0);
    step();
    check("lu_rs_bubble", 32'(o_valid), 32'd0);
    check("lu_rs_bubble_pc", o_pc, 32'h0);
    check("lu_rs_ready2", 32'(o_ready), 32'd1);
    step();
    check("lu_rs_issue", 32'(o_valid), 32'd1);
    check("lu_rs_pc", o_pc, 32'h108);
    check("lu_rs_wr", 32'(o_wr_reg), 32'd5);

    // Load-use on rt via SW
    drive(32'h10C, 32'h8C220004);
    step();
    drive(32'h110, 32'hAC220000);          // SW r2,0(r1)
    check("lu_sw_ready", 32'(o_ready), 32'd0);
    step();
    check("lu_sw_bubble", 32'(o_valid), 32'd0);
    step();
    check("lu_sw_issue", 32'(o_valid), 32'd1);
    check("lu_sw_memwr", 32'(o_mem_wr), 32'd1);
    check("lu_sw_pc", o_pc, 32'h110);

    // No stall when the dependent register is only an I-type destination
    drive(32'h114, 32'h8C220004);
    step();
    drive(32'h118, 32'h24060001);          // ADDIU r6,r0,1
    check("nolu_ready", 32'(o_ready), 32'd1);
    step();
    check("nolu_valid", 32'(o_valid), 32'd1);
    check("nolu_pc", o_pc, 32'h118);
    check("nolu_imm", o_imm_ext, 32'h1);
    check("nolu_wr", 32'(o_wr_reg), 32'd6);

    // Immediate extension
    drive(32'h11C, 32'h34078000);          // ORI r7,r0,0x8000
    step();
    check("ori_imm", o_imm_ext, 32'h00008000);
    check("ori_op", 32'(o_alu_op), 32'd3);
    drive(32'h120, 32'h24078000);          // ADDIU r7,r0,0x8000
    step();
    check("addiu_imm", o_imm_ext, 32'hFFFF8000);
    check("addiu_src", 32'(o_alu_src_imm), 32'd1);
    drive(32'h124, 32'h3C07ABCD);          // LUI r7,0xABCD
    step();
    check("lui_imm", o_imm_ext, 32'hABCD0000);
    check("lui_op", 32'(o_alu_op), 32'd11);

    // Backpressure hold then flush
    drive(32'h200, 32'h0C000100);          // JAL 0x100
    step();
    check("jal_wr", 32'(o_wr_reg), 32'd31);
    check("jal_link", 32'(o_link), 32'd1);
    check("jal_regwr", 32'(o_reg_wr), 32'd1);
    check("jal_imm", o_imm_ext, 32'h100);
    i_ready = 1'b0;
    drive(32'h204, 32'h1022FFFF);          // BEQ r1,r2,-1
    for (int k = 0; k < 3; k++) begin
      check("hold_ready", 32'(o_ready), 32'd0);
      step();
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_pc", o_pc, 32'h200);
      check("hold_imm", o_imm_ext, 32'h100);
      check("hold_link", 32'(o_link), 32'd1);
    end
    i_flush = 1'b1;
    #1;
    check("flush_ready", 32'(o_ready), 32'd1);
    step();
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_pc", o_pc, 32'h0);
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    step();
    check("flush_discard", 32'(o_valid), 32'd0);
    drive(32'h300, 32'h1022FFFF);
    step();
    check("beq_eq", 32'(o_branch_eq), 32'd1);
    check("beq_imm", o_imm_ext, 32'hFFFFFFFF);
    check("beq_op", 32'(o_alu_op), 32'd1);

    // Same-cycle WB and decode of the same register
    wb(5'd9, 32'h11111111);
`ifdef DECODE_WB_BYPASS_EN
    exp_bypass = 32'hDEADBEEF;
`else
    exp_bypass = 32'h11111111;
`endif
    i_wb_en = 1'b1; i_wb_sel = 5'd9; i_wb_data = 32'hDEADBEEF;
    drive(32'h400, 32'h01200826);          // XOR r1,r9,r0
    step();
    i_wb_en = 1'b0;
    check("wbsame_rs", o_rs_data, exp_bypass);
    check("wbsame_op", 32'(o_alu_op), 32'd4);
    step();
    check("wbafter_rs", o_rs_data, 32'hDEADBEEF);

    // r0 writes are ignored
    i_wb_en = 1'b1; i_wb_sel = 5'd0; i_wb_data = 32'hFFFFFFFF;
    drive(32'h404, 32'h00002821);          // ADDU r5,r0,r0
    step();
    i_wb_en = 1'b0;
    check("r0_same", o_rs_data, 32'h0);
    step();
    check("r0_after", o_rs_data, 32'h0);

    // Illegal opcode
    drive(32'h408, 32'hFC000000);
    step();
    check("ill_flag", 32'(o_illegal), 32'd1);
    check("ill_regwr", 32'(o_reg_wr), 32'd0);
    check("ill_memrd", 32'(o_mem_rd), 32'd0);
    check("ill_valid", 32'(o_valid), 32'd1);

    // Reset asserted during a load-use stall
    drive(32'h500, 32'h8C620004);          // LW r2,4(r3)
    step();
    check("lw3_rs", o_rs_data, 32'h12345678);
    drive(32'h504, 32'h00402821);
    check("mid_stall_ready", 32'(o_ready), 32'd0);
    i_rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_rs", o_rs_data, 32'h0);
    check("mid_rst_memrd", 32'(o_mem_rd), 32'd0);
    check("mid_rst_ready", 32'(o_ready), 32'd1);
    step();
    i_rst = 1'b1;
    drive(32'h600, 32'h00A30826);          // XOR r1,r5,r3
    check("post_rst_ready", 32'(o_ready), 32'd1);
    step();
    check("post_rst_valid", 32'(o_valid), 32'd1);
    check("post_rst_r5", o_rs_data, 32'h0);
    check("post_rst_r3", o_rt_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
